// File: rtl/voice_pkg.sv
// Shared constants for the voice capture path: default geometry of the voice RAM
// and the capture sequencer state encoding.
package voice_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 12;
  localparam int DEF_SLOT_BITS = 2;
  localparam int DEF_WPS       = 2 ** (DEF_ADDR_W - DEF_SLOT_BITS);

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_CAPTURE = 3'd1;
  localparam state_t ST_FLUSH   = 3'd2;
  localparam state_t ST_DONE    = 3'd3;
  localparam state_t ST_MATCH   = 3'd4;

endpackage

// File: rtl/pdm_clkgen.sv
// Free-running PDM clock divider: produces the microphone clock and a one-cycle
// sample tick on the last high cycle of each micClk period.
module pdm_clkgen #(
  parameter int CLK_DIV = 40
) (
  input  logic clk,
  input  logic reset,
  output logic mic_clk,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2 - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mic_clk <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      mic_clk <= 1'b1;
    end else if (cnt == CNT_HALF) begin
      mic_clk <= 1'b0;
    end
  end

  // Data is sampled just before micClk falls, when the mic output is settled.
  assign tick = (cnt == CNT_HALF);

endmodule

// File: rtl/voice_capture_ctrl.sv
// PDM capture sequencer: packs mic samples into words, writes them into a voice RAM
// slot, shares the RAM port with recognizer reads and kicks the recognizer.
module voice_capture_ctrl
  import voice_pkg::*;
#(
  parameter int CLK_DIV   = 40,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int SLOT_BITS = DEF_SLOT_BITS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          record,
  input  logic [SLOT_BITS-1:0]          slot_sel,
  input  logic                          micData,
  output logic                          micClk,
  output logic                          ram_wr,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_data,
  input  logic [DATA_W-1:0]             ram_out,
  input  logic                          rd_req,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic                          rd_gnt,
  output logic                          rd_valid,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          match_start,
  input  logic                          match_done,
  output logic                          busy,
  output logic                          cap_done,
  output logic [ADDR_W-SLOT_BITS:0]     cap_len,
  output logic                          overflow
);

  localparam int WIDX_W = ADDR_W - SLOT_BITS;
  localparam int LEN_W  = WIDX_W + 1;
  localparam int WPS    = 2 ** WIDX_W;
  localparam int BIT_W  = $clog2(DATA_W);

  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic [LEN_W-1:0] LAST_WORD = LEN_W'(WPS - 1);

  state_t                 state;
  logic [SLOT_BITS-1:0]   slot;
  logic [LEN_W-1:0]       widx;
  logic [BIT_W-1:0]       bitcnt;
  logic [DATA_W-1:0]      shift;
  logic [ADDR_W-1:0]      wr_addr;
  logic                   tick;
  logic                   rec_s1, rec_s2, rec_d;
  logic                   rec_rise;
  logic [DATA_W-1:0]      word_full;

  pdm_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk     (clk),
    .reset   (reset),
    .mic_clk (micClk),
    .tick    (tick)
  );

  // record is a button level from another domain: two flops, then edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      rec_s1 <= 1'b0;
      rec_s2 <= 1'b0;
      rec_d  <= 1'b0;
    end else begin
      rec_s1 <= record;
      rec_s2 <= rec_s1;
      rec_d  <= rec_s2;
    end
  end

  assign rec_rise  = rec_s2 && !rec_d;
  assign word_full = {micData, shift[DATA_W-2:0]};

  // Sample packing, LSB first; idle clears it so partial words pad with zeros.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE) begin
      shift <= '0;
    end else if (state == ST_CAPTURE && tick) begin
      if (bitcnt == LAST_BIT) begin
        shift <= '0;
      end else begin
        shift[bitcnt] <= micData;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      slot     <= '0;
      widx     <= '0;
      bitcnt   <= '0;
      overflow <= 1'b0;
      cap_len  <= '0;
      ram_wr   <= 1'b0;
      ram_data <= '0;
    end else begin
      ram_wr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rec_rise) begin
            slot     <= slot_sel;
            widx     <= '0;
            bitcnt   <= '0;
            overflow <= 1'b0;
            state    <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (tick) begin
            if (bitcnt == LAST_BIT) begin
              // A completed word is always written, even if record just dropped.
              ram_wr   <= 1'b1;
              wr_addr  <= {slot, widx[WIDX_W-1:0]};
              ram_data <= word_full;
              widx     <= widx + 1'b1;
              bitcnt   <= '0;
              if (widx == LAST_WORD) begin
                overflow <= 1'b1;
                state    <= ST_DONE;
              end else if (!rec_s2) begin
                state <= ST_DONE;
              end
            end else begin
              bitcnt <= bitcnt + 1'b1;
              if (!rec_s2) begin
                state <= ST_FLUSH;
              end
            end
          end else if (!rec_s2) begin
            state <= (bitcnt != '0) ? ST_FLUSH : ST_DONE;
          end
        end
        ST_FLUSH: begin
          ram_wr   <= 1'b1;
          wr_addr  <= {slot, widx[WIDX_W-1:0]};
          ram_data <= shift;
          widx     <= widx + 1'b1;
          if (widx == LAST_WORD) begin
            overflow <= 1'b1;
          end
          state <= ST_DONE;
        end
        ST_DONE: begin
          cap_len <= widx;
          state   <= (slot == '0) ? ST_MATCH : ST_IDLE;
        end
        ST_MATCH: begin
          if (match_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Writes own the port; a read is only granted in a non-write cycle.
  assign rd_gnt   = rd_req && !ram_wr;
  assign ram_addr = ram_wr ? wr_addr : (rd_gnt ? rd_addr : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_gnt;
    end
  end

  assign rd_data     = rd_valid ? ram_out : '0;
  assign busy        = (state != ST_IDLE);
  assign cap_done    = (state == ST_DONE);
  assign match_start = (state == ST_DONE) && (slot == '0);

endmodule

// File: tb/tb_voice_capture_ctrl.sv
// Scoreboard bench for voice_capture_ctrl: models the expected RAM writes from the
// driven PDM stream and checks arbitration, read return and capture status.
module tb_voice_capture_ctrl;

  localparam int CLK_DIV   = 4;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 32;
  localparam int SLOT_BITS = 2;
  localparam int WPS       = 2 ** (ADDR_W - SLOT_BITS);
  localparam int LEN_W     = ADDR_W - SLOT_BITS + 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 record;
  logic [SLOT_BITS-1:0] slot_sel;
  logic                 micData;
  logic                 micClk;
  logic                 ram_wr;
  logic [ADDR_W-1:0]    ram_addr;
  logic [DATA_W-1:0]    ram_data;
  logic [DATA_W-1:0]    ram_out;
  logic                 rd_req;
  logic [ADDR_W-1:0]    rd_addr;
  logic                 rd_gnt;
  logic                 rd_valid;
  logic [DATA_W-1:0]    rd_data;
  logic                 match_start;
  logic                 match_done;
  logic                 busy;
  logic                 cap_done;
  logic [LEN_W-1:0]     cap_len;
  logic                 overflow;

  voice_capture_ctrl #(
    .CLK_DIV   (CLK_DIV),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .SLOT_BITS (SLOT_BITS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .record      (record),
    .slot_sel    (slot_sel),
    .micData     (micData),
    .micClk      (micClk),
    .ram_wr      (ram_wr),
    .ram_addr    (ram_addr),
    .ram_data    (ram_data),
    .ram_out     (ram_out),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_gnt      (rd_gnt),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .match_start (match_start),
    .match_done  (match_done),
    .busy        (busy),
    .cap_done    (cap_done),
    .cap_len     (cap_len),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_cap = 0;
  int n_ms = 0;
  int n_both = 0;
  int n_deny = 0;
  int m_cnt = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] mem [0:2**ADDR_W-1];
  logic rd_pend = 1'b0;
  logic [DATA_W-1:0] rd_exp;
  logic rd_run;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_data;
    ram_out <= mem[ram_addr];
  end

  // Reference phase of the micClk divider.
  always @(posedge clk) begin
    if (reset) m_cnt <= 0;
    else m_cnt <= (m_cnt == CLK_DIV - 1) ? 0 : m_cnt + 1;
  end

  // Output monitor: write scoreboard, arbitration and read return.
  always @(negedge clk) begin
    if (reset) begin
      rd_pend <= 1'b0;
    end else begin
      if (rd_pend) begin
        chk("rd_valid", rd_valid, 1'b1);
        chk("rd_data", rd_data, rd_exp);
      end
      rd_pend <= 1'b0;
      if (rd_req) begin
        chk("rd_gnt", rd_gnt, !ram_wr);
        if (ram_wr && !rd_gnt) n_deny <= n_deny + 1;
        if (rd_gnt) begin
          chk("rd_addr", ram_addr, rd_addr);
          rd_pend <= 1'b1;
          rd_exp  <= mem[rd_addr];
        end
      end
      if (ram_wr) begin
        if (exp_q.size() == 0) begin
          chk("spurious_wr", ram_wr, 1'b0);
        end else begin
          logic [ADDR_W+DATA_W-1:0] e;
          e = exp_q.pop_front();
          chk("wr_addr", ram_addr, e[ADDR_W+DATA_W-1:DATA_W]);
          chk("wr_data", ram_data, e[DATA_W-1:0]);
        end
      end
      if (cap_done) n_cap <= n_cap + 1;
      if (match_start) n_ms <= n_ms + 1;
      if (cap_done && match_start) n_both <= n_both + 1;
    end
  end

  task automatic drive_tick(input logic d);
    micData = d;
    do begin
      @(posedge clk);
      #1;
    end while (m_cnt != CLK_DIV / 2);
  endtask

  // mode 0: alternating from 1, mode 1: all ones, mode 2: random.
  task automatic run_capture(input int slot, input int nticks, input int mode, output int words);
    logic [DATA_W-1:0] w;
    logic [ADDR_W-1:0] a;
    logic d;
    int b, widx;
    slot_sel = SLOT_BITS'(slot);
    record = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    w = '0; b = 0; widx = 0;
    for (int i = 0; i < nticks; i++) begin
      case (mode)
        0: d = (i % 2 == 0);
        1: d = 1'b1;
        default: d = 1'($urandom_range(0, 1));
      endcase
      drive_tick(d);
      if (widx < WPS) begin
        w[b] = d;
        b++;
        if (b == DATA_W) begin
          a = ADDR_W'(slot * WPS + widx);
          exp_q.push_back({a, w});
          widx++; b = 0; w = '0;
        end
      end
    end
    record = 1'b0;
    if (b > 0 && widx < WPS) begin
      a = ADDR_W'(slot * WPS + widx);
      exp_q.push_back({a, w});
      widx++;
    end
    words = widx;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    int words, c0, m0, b0;
    for (int i = 0; i < 2 ** ADDR_W; i++) mem[i] = '0;
    reset = 1'b1; record = 1'b0; slot_sel = '0; micData = 1'b0;
    rd_req = 1'b0; rd_addr = '0; match_done = 1'b0; rd_run = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;

    // Idle: divider waveform and quiet outputs.
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (i >= CLK_DIV) chk("micClk", micClk, m_cnt < CLK_DIV / 2);
    end
    chk("idle_busy", busy, 1'b0);
    chk("idle_ram_wr", ram_wr, 1'b0);
    chk("idle_ram_addr", ram_addr, 0);
    chk("idle_ram_data", ram_data, 0);
    chk("idle_rd_valid", rd_valid, 1'b0);
    chk("idle_cap_len", cap_len, 0);
    chk("idle_overflow", overflow, 1'b0);

    // Template slot 1: two alternating words.
    c0 = n_cap; m0 = n_ms;
    run_capture(1, 64, 0, words);
    chk("s1_cap_len", cap_len, 2);
    chk("s1_overflow", overflow, 1'b0);
    chk("s1_cap_done", n_cap - c0, 1);
    chk("s1_match_start", n_ms - m0, 0);
    chk("s1_busy", busy, 1'b0);
    chk("s1_pending", exp_q.size(), 0);

    // Test slot 0: full word plus partial, then recognizer handshake.
    c0 = n_cap; m0 = n_ms; b0 = n_both;
    run_capture(0, 40, 1, words);
    chk("s0_cap_len", cap_len, 2);
    chk("s0_cap_done", n_cap - c0, 1);
    chk("s0_match_same_cycle", n_both - b0, 1);
    chk("s0_pending", exp_q.size(), 0);
    repeat (10) @(posedge clk);
    #1;
    chk("s0_busy_match", busy, 1'b1);
    match_done = 1'b1;
    @(posedge clk);
    #1 match_done = 1'b0;
    chk("s0_busy_after_done", busy, 1'b0);

    // Slot 2 with continuous recognizer reads of addresses 0/1.
    c0 = n_deny;
    rd_run = 1'b1;
    fork
      begin
        run_capture(2, 69, 2, words);
        rd_run = 1'b0;
      end
      begin
        while (rd_run) begin
          rd_req = 1'b1;
          @(posedge clk);
          #1 rd_addr = rd_addr ^ ADDR_W'(1);
        end
        rd_req = 1'b0;
      end
    join
    @(posedge clk);
    #1;
    chk("s2_cap_len", cap_len, 3);
    chk("s2_denied", n_deny - c0, 3);
    chk("s2_pending", exp_q.size(), 0);

    // Slot 3 held past the slot end.
    c0 = n_cap; m0 = n_ms;
    run_capture(3, WPS * DATA_W + 50, 2, words);
    chk("s3_cap_len", cap_len, WPS);
    chk("s3_overflow", overflow, 1'b1);
    chk("s3_cap_done", n_cap - c0, 1);
    chk("s3_match_start", n_ms - m0, 0);
    chk("s3_pending", exp_q.size(), 0);

    // Reset in the middle of a capture.
    slot_sel = 2'd1;
    record = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("restart_overflow_clr", overflow, 1'b0);
    chk("restart_busy", busy, 1'b1);
    for (int i = 0; i < 20; i++) drive_tick(1'($urandom_range(0, 1)));
    reset = 1'b1;
    record = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_micClk", micClk, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ram_wr", ram_wr, 1'b0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_data", ram_data, 0);
    chk("rst_rd_gnt", rd_gnt, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_cap_done", cap_done, 1'b0);
    chk("rst_match_start", match_start, 1'b0);
    chk("rst_cap_len", cap_len, 0);
    chk("rst_overflow", overflow, 1'b0);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_pending", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
